memory_interface_arbiter: RTL

Shares one single-ported memory between the core's instruction and data memory interfaces. Each side issues a held request; the arbiter grants one at a time, drives the memory port, and returns data with a one-cycle ready pulse. A timeout converts a hung memory into a bus-error response. Sits between the core and the unified memory in both SoC top and bench.

---
 rtl/memory_interface_arbiter_if.sv | 47 ++++
 rtl/memory_interface_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/memory_interface_arbiter_if.sv
// Core-side instruction/data request buses plus the shared single-ported memory port.
// The arbiter connects through the slave modport; the core/memory side uses master.
interface memory_interface_arbiter_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                      instruction_request;
  logic [ADDRESS_WIDTH-1:0]  instruction_address;
  logic [DATA_WIDTH-1:0]     instruction_read_data;
  logic                      instruction_ready;
  logic                      instruction_error;

  logic                      data_request;
  logic                      data_write;
  logic [ADDRESS_WIDTH-1:0]  data_address;
  logic [DATA_WIDTH/8-1:0]   data_frame_mask;
  logic [DATA_WIDTH-1:0]     data_write_data;
  logic [DATA_WIDTH-1:0]     data_read_data;
  logic                      data_ready;
  logic                      data_error;

  logic                      mem_enable;
  logic                      mem_write;
  logic [ADDRESS_WIDTH-1:0]  mem_address;
  logic [DATA_WIDTH/8-1:0]   mem_frame_mask;
  logic [DATA_WIDTH-1:0]     mem_write_data;
  logic [DATA_WIDTH-1:0]     mem_read_data;
  logic                      mem_ready;

  modport slave (
    input  instruction_request, instruction_address,
    output instruction_read_data, instruction_ready, instruction_error,
    input  data_request, data_write, data_address, data_frame_mask, data_write_data,
    output data_read_data, data_ready, data_error,
    output mem_enable, mem_write, mem_address, mem_frame_mask, mem_write_data,
    input  mem_read_data, mem_ready
  );

  modport master (
    output instruction_request, instruction_address,
    input  instruction_read_data, instruction_ready, instruction_error,
    output data_request, data_write, data_address, data_frame_mask, data_write_data,
    input  data_read_data, data_ready, data_error,
    input  mem_enable, mem_write, mem_address, mem_frame_mask, mem_write_data,
    output mem_read_data, mem_ready
  );
endinterface

// File: rtl/memory_interface_arbiter.sv
// Shares one single-ported memory between instruction and data requesters, with a bus-error timeout.
// Define ARBITER_ROUND_ROBIN_EN to alternate ties between ports instead of data-over-instruction priority.
module memory_interface_arbiter #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clk,
  input logic reset,
  memory_interface_arbiter_if.slave bus
);
  localparam int MaskWidth  = DATA_WIDTH / 8;
  localparam int CountWidth = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CountWidth-1:0] CountLast =
    CountWidth'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e                   state_q;
  logic                     grantData_q;
  logic [CountWidth-1:0]    timeoutCount_q;
  logic                     memEnable_q;
  logic                     memWrite_q;
  logic [ADDRESS_WIDTH-1:0] memAddress_q;
  logic [MaskWidth-1:0]     memFrameMask_q;
  logic [DATA_WIDTH-1:0]    memWriteData_q;
  logic [DATA_WIDTH-1:0]    instrReadData_q;
  logic                     instrReady_q;
  logic                     instrError_q;
  logic [DATA_WIDTH-1:0]    dataReadData_q;
  logic                     dataReady_q;
  logic                     dataError_q;
  logic                     grantData_d;

`ifdef ARBITER_ROUND_ROBIN_EN
  logic                     lastGrantData_q;
`endif

  // Winner for the next IDLE grant; only a tie consults the grant history.
  always_comb begin
    grantData_d = bus.data_request;
`ifdef ARBITER_ROUND_ROBIN_EN
    if (bus.data_request && bus.instruction_request) grantData_d = !lastGrantData_q;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      grantData_q     <= 1'b0;
      timeoutCount_q  <= '0;
      memEnable_q     <= 1'b0;
      memWrite_q      <= 1'b0;
      memAddress_q    <= '0;
      memFrameMask_q  <= '0;
      memWriteData_q  <= '0;
      instrReadData_q <= '0;
      instrReady_q    <= 1'b0;
      instrError_q    <= 1'b0;
      dataReadData_q  <= '0;
      dataReady_q     <= 1'b0;
      dataError_q     <= 1'b0;
`ifdef ARBITER_ROUND_ROBIN_EN
      lastGrantData_q <= 1'b0;
`endif
    end else begin
      instrReady_q <= 1'b0;
      instrError_q <= 1'b0;
      dataReady_q  <= 1'b0;
      dataError_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.data_request || bus.instruction_request) begin
            grantData_q    <= grantData_d;
            memEnable_q    <= 1'b1;
            timeoutCount_q <= '0;
            state_q        <= BUSY;
`ifdef ARBITER_ROUND_ROBIN_EN
            lastGrantData_q <= grantData_d;
`endif
            if (grantData_d) begin
              memWrite_q     <= bus.data_write;
              memAddress_q   <= bus.data_address;
              memFrameMask_q <= bus.data_frame_mask;
              memWriteData_q <= bus.data_write_data;
            end else begin
              memWrite_q     <= 1'b0;
              memAddress_q   <= bus.instruction_address;
              memFrameMask_q <= '1;
              memWriteData_q <= '0;
            end
          end
        end
        BUSY: begin
          // A completing memory wins over a timeout expiring on the same edge.
          if (bus.mem_ready) begin
            memEnable_q <= 1'b0;
            state_q     <= RESP;
            if (grantData_q) begin
              dataReadData_q <= memWrite_q ? '0 : bus.mem_read_data;
              dataReady_q    <= 1'b1;
            end else begin
              instrReadData_q <= bus.mem_read_data;
              instrReady_q    <= 1'b1;
            end
          end else if (TIMEOUT_CYCLES != 0 && timeoutCount_q == CountLast) begin
            memEnable_q <= 1'b0;
            state_q     <= RESP;
            if (grantData_q) begin
              dataReadData_q <= '0;
              dataReady_q    <= 1'b1;
              dataError_q    <= 1'b1;
            end else begin
              instrReadData_q <= '0;
              instrReady_q    <= 1'b1;
              instrError_q    <= 1'b1;
            end
          end else if (TIMEOUT_CYCLES != 0) begin
            timeoutCount_q <= timeoutCount_q + CountWidth'(1);
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_enable            = memEnable_q;
  assign bus.mem_write             = memWrite_q;
  assign bus.mem_address           = memAddress_q;
  assign bus.mem_frame_mask        = memFrameMask_q;
  assign bus.mem_write_data        = memWriteData_q;
  assign bus.instruction_read_data = instrReadData_q;
  assign bus.instruction_ready     = instrReady_q;
  assign bus.instruction_error     = instrError_q;
  assign bus.data_read_data        = dataReadData_q;
  assign bus.data_ready            = dataReady_q;
  assign bus.data_error            = dataError_q;
endmodule
